mem_stage: RTL and testbench

//  Memory-access pipeline stage between EXE and WB of the LoongArch-subset CPU.

---
 rtl/mem_stage.sv | 141 ++++++++++++++
 tb/tb_mem_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: registers the EXE payload, aligns/extends load data from the
// synchronous data SRAM, selects the writeback value and drives the WB and forward buses.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 78,
    parameter int MS_TO_WS_BUS_WD = 70,
    parameter int MS_TO_DS_BUS_WD = 38
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_forward_bus,
    output logic                       ms_to_ds_valid,
    input  logic [63:0]                mul_product,
    input  logic [31:0]                div_quotient,
    input  logic [31:0]                div_remainder,
    input  logic [31:0]                data_sram_rdata
);

    logic                       ms_valid;
    logic                       ms_ready_go;
    logic                       accept;
    logic [ES_TO_MS_BUS_WD-1:0] bus_r;

    logic        sext;
    logic [1:0]  size;
    logic [3:0]  mdop;
    logic        load;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_res;
    logic [31:0] pc;

    logic        ld_hold_vld;
    logic [31:0] ld_hold_r;
    logic        ld_hold_set;
    logic [31:0] raw;
    logic [1:0]  addr_lo;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        fwd_en;

    assign sext    = bus_r[77];
    assign size    = bus_r[76:75];
    assign mdop    = bus_r[74:71];
    assign load    = bus_r[70];
    assign gr_we   = bus_r[69];
    assign dest    = bus_r[68:64];
    assign alu_res = bus_r[63:32];
    assign pc      = bus_r[31:0];

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_to_ds_valid = ms_valid;
    assign accept         = ms_allowin && es_to_ms_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            bus_r <= es_to_ms_bus;
        end
    end

    // The SRAM only presents read data for one cycle, so a stalled load keeps its own copy.
    assign ld_hold_set = ms_valid && load && !ws_allowin && !ld_hold_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_hold_vld <= 1'b0;
        end else if (accept) begin
            ld_hold_vld <= 1'b0;
        end else if (ld_hold_set) begin
            ld_hold_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_hold_set) begin
            ld_hold_r <= data_sram_rdata;
        end
    end

    assign raw     = ld_hold_vld ? ld_hold_r : data_sram_rdata;
    assign addr_lo = alu_res[1:0];

    always_comb begin
        byte_sel = raw[7:0];
        case (addr_lo)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
    end

    assign half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        load_data = raw;
        if (size[0]) begin
            load_data = {{24{sext & byte_sel[7]}}, byte_sel};
        end else if (size[1]) begin
            load_data = {{16{sext & half_sel[15]}}, half_sel};
        end
    end

    always_comb begin
        final_result = alu_res;
        if (load) begin
            final_result = load_data;
        end else if (mdop[0]) begin
            final_result = mul_product[31:0];
        end else if (mdop[1]) begin
            final_result = mul_product[63:32];
        end else if (mdop[2]) begin
            final_result = div_quotient;
        end else if (mdop[3]) begin
            final_result = div_remainder;
        end
    end

    assign fwd_en = ms_valid && gr_we && (dest != 5'd0);

    assign ms_to_ws_bus         = {gr_we, dest, final_result, pc};
    assign ms_to_ds_forward_bus = {fwd_en, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed corner cases followed by randomized traffic
// compared against an instruction-level reference model.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [77:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [37:0] ms_to_ds_forward_bus;
    logic        ms_to_ds_valid;
    logic [63:0] mul_product;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic [31:0] data_sram_rdata;

    int nchk = 0;
    int nerr = 0;

    // Reference model: the instruction currently in MEM and the SRAM word it got.
    logic        m_valid;
    logic        m_first;
    logic [77:0] m_bus;
    logic [31:0] m_rdata;

    mem_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .ws_allowin           (ws_allowin),
        .ms_allowin           (ms_allowin),
        .es_to_ms_valid       (es_to_ms_valid),
        .es_to_ms_bus         (es_to_ms_bus),
        .ms_to_ws_valid       (ms_to_ws_valid),
        .ms_to_ws_bus         (ms_to_ws_bus),
        .ms_to_ds_forward_bus (ms_to_ds_forward_bus),
        .ms_to_ds_valid       (ms_to_ds_valid),
        .mul_product          (mul_product),
        .div_quotient         (div_quotient),
        .div_remainder        (div_remainder),
        .data_sram_rdata      (data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [77:0] mk(input logic sx, input logic [1:0] sz, input logic [3:0] md,
                                       input logic ld, input logic we, input logic [4:0] d,
                                       input logic [31:0] alu, input logic [31:0] pcv);
        return {sx, sz, md, ld, we, d, alu, pcv};
    endfunction

    function automatic logic [31:0] ref_result(input logic [77:0] b, input logic [31:0] word);
        int unsigned a;
        logic [31:0] v;
        a = b[33:32];
        v = b[63:32];
        if (b[70]) begin
            if (b[76:75] == 2'b01) begin
                v = (word >> (8 * a)) & 32'h0000_00FF;
                if (b[77] && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end else if (b[76:75] == 2'b10) begin
                v = (word >> ((a >= 2) ? 16 : 0)) & 32'h0000_FFFF;
                if (b[77] && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = word;
            end
        end else begin
            case (b[74:71])
                4'b0001: v = mul_product[31:0];
                4'b0010: v = mul_product[63:32];
                4'b0100: v = div_quotient;
                4'b1000: v = div_remainder;
                default: v = b[63:32];
            endcase
        end
        return v;
    endfunction

    task automatic check_outputs();
        logic [31:0] word;
        logic [31:0] fr;
        chk("ms_allowin", ms_allowin, !m_valid || ws_allowin);
        chk("ws_valid", ms_to_ws_valid, m_valid);
        chk("ds_valid", ms_to_ds_valid, m_valid);
        if (m_valid) begin
            // A load's data is whatever the SRAM returned in its first cycle in MEM.
            if (m_first) m_rdata = data_sram_rdata;
            word = m_rdata;
            fr = ref_result(m_bus, word);
            chk("ws_bus", ms_to_ws_bus, {m_bus[69], m_bus[68:64], fr, m_bus[31:0]});
            chk("fwd_bus", ms_to_ds_forward_bus,
                {32'd0, m_bus[69] && (m_bus[68:64] != 5'd0), m_bus[68:64], fr});
        end else begin
            chk("fwd_en_idle", ms_to_ds_forward_bus[37], 1'b0);
        end
    endtask

    task automatic drive(input logic r, input logic ev, input logic [77:0] b,
                         input logic wa, input logic [31:0] rd);
        reset           = r;
        es_to_ms_valid  = ev;
        es_to_ms_bus    = b;
        ws_allowin      = wa;
        data_sram_rdata = rd;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_first = 1'b0;
        end else begin
            m_first = 1'b0;
            if (!m_valid || ws_allowin) begin
                m_valid = es_to_ms_valid;
                if (es_to_ms_valid) begin
                    m_bus   = es_to_ms_bus;
                    m_first = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic rnd_md();
        mul_product   = {$urandom, $urandom};
        div_quotient  = $urandom;
        div_remainder = $urandom;
    endtask

    initial begin
        logic [77:0] b;
        logic [1:0]  sz;
        logic [3:0]  md;
        logic [4:0]  d;
        int          k;

        reset = 1'b1;
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        data_sram_rdata = '0;
        rnd_md();
        m_valid = 1'b0;
        m_first = 1'b0;
        m_bus = '0;
        m_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        drive(0, 0, '0, 0, $urandom);
        chk("reset_ws_valid", ms_to_ws_valid, 1'b0);
        chk("reset_allowin", ms_allowin, 1'b1);
        tick();

        // ld.b at byte 3, signed then unsigned
        drive(0, 1, mk(1, 2'b01, 4'd0, 1, 1, 5'd5, 32'h0000_1003, 32'h1C00_0000), 1, $urandom);
        tick();
        drive(0, 1, mk(0, 2'b01, 4'd0, 1, 1, 5'd6, 32'h0000_1003, 32'h1C00_0004), 1, 32'h80FF_7F01);
        chk("ldb_sext", ms_to_ws_bus[63:32], 32'hFFFF_FF80);
        tick();
        drive(0, 1, mk(1, 2'b10, 4'd0, 1, 1, 5'd7, 32'h0000_2002, 32'h1C00_0008), 1, 32'h80FF_7F01);
        chk("ldb_zext", ms_to_ws_bus[63:32], 32'h0000_0080);
        tick();
        // ld.h upper half signed, then lower half
        drive(0, 1, mk(1, 2'b10, 4'd0, 1, 1, 5'd8, 32'h0000_2000, 32'h1C00_000C), 1, 32'h8001_7FFE);
        chk("ldh_hi_sext", ms_to_ws_bus[63:32], 32'hFFFF_8001);
        tick();
        drive(0, 0, '0, 1, 32'h8001_7FFE);
        chk("ldh_lo", ms_to_ws_bus[63:32], 32'h0000_7FFE);
        tick();

        // ld.w stalled by WB for 3 cycles with SRAM data changing every cycle
        drive(0, 1, mk(0, 2'b00, 4'd0, 1, 1, 5'd9, 32'h0000_3000, 32'h1C00_0010), 1, $urandom);
        tick();
        drive(0, 0, '0, 0, 32'hAAAA_0001);
        chk("ldw_stall0", ms_to_ws_bus[63:32], 32'hAAAA_0001);
        tick();
        drive(0, 1, mk(0, 2'b00, 4'd0, 0, 1, 5'd3, 32'h5, 32'h1C00_0014), 0, 32'hBBBB_0002);
        chk("ldw_stall1", ms_to_ws_bus[63:32], 32'hAAAA_0001);
        chk("ldw_stall_allowin", ms_allowin, 1'b0);
        tick();
        drive(0, 0, '0, 0, 32'hCCCC_0003);
        chk("ldw_stall2", ms_to_ws_bus[63:32], 32'hAAAA_0001);
        chk("ldw_stall_valid", ms_to_ws_valid, 1'b1);
        tick();
        drive(0, 0, '0, 1, 32'hDDDD_0004);
        chk("ldw_release", ms_to_ws_bus[63:32], 32'hAAAA_0001);
        tick();

        // mulh and mod select
        drive(0, 1, mk(0, 2'b00, 4'b0010, 0, 1, 5'd10, 32'h1, 32'h1C00_0018), 1, $urandom);
        tick();
        mul_product = 64'h1234_5678_9ABC_DEF0;
        drive(0, 1, mk(0, 2'b00, 4'b1000, 0, 1, 5'd11, 32'h2, 32'h1C00_001C), 1, $urandom);
        chk("mulh", ms_to_ws_bus[63:32], 32'h1234_5678);
        tick();
        div_quotient = 32'h0000_0042;
        div_remainder = 32'h0000_0007;
        drive(0, 0, '0, 1, $urandom);
        chk("mod", ms_to_ws_bus[63:32], 32'h0000_0007);
        tick();

        // back-to-back add r4 then add r0
        drive(0, 1, mk(0, 2'b00, 4'd0, 0, 1, 5'd4, 32'h0000_0123, 32'h1C00_0020), 1, $urandom);
        tick();
        drive(0, 1, mk(0, 2'b00, 4'd0, 0, 1, 5'd0, 32'h0000_0456, 32'h1C00_0024), 1, $urandom);
        chk("fwd_r4", ms_to_ds_forward_bus[37], 1'b1);
        tick();
        drive(0, 0, '0, 1, $urandom);
        chk("fwd_r0", ms_to_ds_forward_bus[37], 1'b0);
        chk("r0_valid", ms_to_ws_valid, 1'b1);
        tick();

        // reset while a load is held, then a fresh load sees live SRAM data
        drive(0, 1, mk(0, 2'b00, 4'd0, 1, 1, 5'd12, 32'h0000_4000, 32'h1C00_0028), 1, $urandom);
        tick();
        drive(0, 0, '0, 0, 32'h1111_1111);
        tick();
        drive(1, 0, '0, 0, 32'h2222_2222);
        tick();
        drive(0, 0, '0, 0, $urandom);
        chk("rst_clears_valid", ms_to_ws_valid, 1'b0);
        tick();
        drive(0, 1, mk(0, 2'b00, 4'd0, 1, 1, 5'd13, 32'h0000_4004, 32'h1C00_002C), 0, $urandom);
        tick();
        drive(0, 0, '0, 1, 32'h3333_3333);
        chk("post_rst_live", ms_to_ws_bus[63:32], 32'h3333_3333);
        tick();

        for (int i = 0; i < 3000; i++) begin
            k  = $urandom_range(0, 2);
            sz = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
            k  = $urandom_range(0, 4);
            md = (k == 0) ? 4'd0 : 4'(1 << (k - 1));
            d  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            b  = mk(1'($urandom), sz, md, 1'($urandom), 1'($urandom), d, $urandom, $urandom);
            rnd_md();
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), b,
                  ($urandom_range(0, 2) != 0), $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
